// File: rtl/dmcache_pkg.sv
// Shared types for the direct-mapped cache write side: default widths,
// cache line and write-buffer entry layouts, and the drain FSM states.
package dmcache_pkg;

   localparam int unsigned AW_DEF    = 8;
   localparam int unsigned DW_DEF    = 8;
   localparam int unsigned IW_DEF    = 3;
   localparam int unsigned DEPTH_DEF = 4;

   // Cache line as stored in the line array: {tag, data}
   typedef struct packed {
      logic [AW_DEF-IW_DEF-1:0] tag;
      logic [DW_DEF-1:0]        data;
   } line_t;

   // Write-buffer entry: one pending RAM write
   typedef struct packed {
      logic [AW_DEF-1:0] addr;
      logic [DW_DEF-1:0] data;
   } wbuf_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } drain_state_e;

endpackage

// File: rtl/dmcache_writer_wbuf_fifo.sv
// wbuf_fifo: DEPTH-entry circular write buffer with push/pop, head read,
// tail data overwrite, a tail address match and a parallel address lookup
// across all occupied entries.
module wbuf_fifo #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [AW-1:0]                push_addr,
   input  logic [DW-1:0]                push_data,
   input  logic                         pop,
   input  logic                         ovw,
   input  logic [DW-1:0]                ovw_data,
   output logic [AW-1:0]                head_addr,
   output logic [DW-1:0]                head_data,
   input  logic [AW-1:0]                cmp_addr,
   output logic                         tail_hit,
   input  logic [AW-1:0]                chk_addr,
   output logic                         chk_hit,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [AW-1:0] addr_q [DEPTH];
   logic [AW-1:0] addr_d [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [DW-1:0] data_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] tail_ptr;

   assign tail_ptr  = wr_ptr_q - PW'(1);
   assign head_addr = addr_q[rd_ptr_q];
   assign head_data = data_q[rd_ptr_q];
   assign tail_hit  = (count_q != '0) && (addr_q[tail_ptr] == cmp_addr);
   assign count     = count_q;

   // Next-state for storage, pointers and occupancy
   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         addr_d[wr_ptr_q] = push_addr;
         data_d[wr_ptr_q] = push_data;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (ovw) begin
         data_d[tail_ptr] = ovw_data;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Address lookup over occupied entries (head..tail) for read hazards
   always_comb begin
      logic [PW-1:0] off;
      off     = '0;
      chk_hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rd_ptr_q;
         if ((CW'(off) < count_q) && (addr_q[i] == chk_addr)) begin
            chk_hit = 1'b1;
         end
      end
   end

   // Buffer state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/dmcache_writer.sv
// dmcache_writer: write side of the direct-mapped cache. Accepted CPU byte
// writes update the cache line array (write-allocate) and are posted into a
// write buffer that drains to RAM over a req/ack handshake (write-through).
// Optional build macro WR_COALESCE_EN: a write to the tail entry's address
// merges into that entry instead of taking a new slot.
module dmcache_writer
   import dmcache_pkg::*;
#(
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned IW    = IW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [AW-1:0]               wr_addr,
   input  logic [DW-1:0]               wr_data,
   output logic                        upd_valid,
   output logic [IW-1:0]               upd_index,
   output logic [AW-IW+DW-1:0]         upd_line,
   output logic                        mem_req,
   output logic [AW-1:0]               mem_addr,
   output logic [DW-1:0]               mem_data,
   input  logic                        mem_ack,
   input  logic [AW-1:0]               chk_addr,
   output logic                        chk_pending,
   output logic                        busy,
   output logic [$clog2(DEPTH+1)-1:0]  count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned LW = AW - IW + DW;

`ifdef WR_COALESCE_EN
   localparam bit COALESCE = 1'b1;
`else
   localparam bit COALESCE = 1'b0;
`endif

   drain_state_e   state_q, state_d;
   logic           mem_req_q, mem_req_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;
   logic [DW-1:0]  mem_data_q, mem_data_d;
   logic           upd_valid_q, upd_valid_d;
   logic [IW-1:0]  upd_index_q, upd_index_d;
   logic [LW-1:0]  upd_line_q, upd_line_d;

   logic           pop;
   logic           push;
   logic           wr_fire;
   logic           coal_hit;
   logic           tail_hit;
   logic [AW-1:0]  head_addr;
   logic [DW-1:0]  head_data;
   logic [CW-1:0]  fifo_count;

   // Write acceptance; a merge into the tail entry bypasses the full check,
   // except when the tail is the head currently being presented to RAM
   assign wr_ready = (fifo_count < CW'(DEPTH));
   assign coal_hit = COALESCE & wr_valid & tail_hit
                   & ~((fifo_count == CW'(1)) & (state_q == REQ));
   assign wr_fire  = wr_valid & (wr_ready | coal_hit);
   assign push     = wr_fire & ~coal_hit;

   wbuf_fifo #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_wbuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_addr (wr_addr),
      .push_data (wr_data),
      .pop       (pop),
      .ovw       (coal_hit),
      .ovw_data  (wr_data),
      .head_addr (head_addr),
      .head_data (head_data),
      .cmp_addr  (wr_addr),
      .tail_hit  (tail_hit),
      .chk_addr  (chk_addr),
      .chk_hit   (chk_pending),
      .count     (fifo_count)
   );

   // Cache line update: one-cycle pulse with {tag, data} of the accepted write
   always_comb begin
      upd_valid_d = wr_fire;
      upd_index_d = upd_index_q;
      upd_line_d  = upd_line_q;
      if (wr_fire) begin
         upd_index_d = wr_addr[IW-1:0];
         upd_line_d  = {wr_addr[AW-1:IW], wr_data};
      end
   end

   // Drain FSM: load head in IDLE, hold request until ack pops the head
   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (fifo_count != '0) begin
               state_d    = REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = head_addr;
               // A merge into a lone entry lands this edge; forward its data
               mem_data_d = (coal_hit && (fifo_count == CW'(1))) ? wr_data : head_data;
            end
         end
         REQ: begin
            if (mem_ack) begin
               pop       = 1'b1;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State, RAM port and update port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         upd_valid_q <= 1'b0;
         upd_index_q <= '0;
         upd_line_q  <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         upd_valid_q <= upd_valid_d;
         upd_index_q <= upd_index_d;
         upd_line_q  <= upd_line_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;
   assign upd_valid = upd_valid_q;
   assign upd_index = upd_index_q;
   assign upd_line  = upd_line_q;
   assign busy      = (fifo_count != '0) | mem_req_q;
   assign count     = fifo_count;

endmodule
